// File: rtl/prio_arbiter_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : prio_arbiter_pkg
// Brief   : Shared definitions for the 8-requester arbiter: sizes, default
//           hold limit and FSM state encodings.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
package prio_arbiter_pkg;

   localparam int ARB_N        = 8;
   localparam int ARB_IDXW     = 3;
   localparam int ARB_MAX_HOLD = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/prio_pick.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : prio_pick
// Brief   : Combinational highest-set-bit encoder with a valid flag.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module prio_pick
   import prio_arbiter_pkg::*;
#(
   parameter int N    = ARB_N,
   parameter int IDXW = ARB_IDXW
) (
   input  logic [N-1:0]    req_i,
   output logic [IDXW-1:0] idx_o,
   output logic            valid_o
);

   // Ascending scan: the last set bit seen is the highest one
   always_comb begin
      idx_o   = '0;
      valid_o = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (req_i[i]) begin
            idx_o   = IDXW'(i);
            valid_o = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/prio_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : prio_arbiter
// Brief   : 8-requester arbiter, fixed-priority or round-robin, with grant
//           hold, hold-limit timeout and a one-cycle turnaround gap.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module prio_arbiter
   import prio_arbiter_pkg::*;
#(
   parameter int N        = ARB_N,
   parameter int IDXW     = ARB_IDXW,
   parameter int MAX_HOLD = ARB_MAX_HOLD
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    req,
   input  logic            rr_mode,
   output logic [N-1:0]    grant,
   output logic [IDXW-1:0] grant_idx,
   output logic            grant_valid,
   output logic            timeout
);

   localparam int HW = $clog2(MAX_HOLD);

   state_t          state_q, state_d;
   logic [HW-1:0]   hold_q, hold_d;
   logic [IDXW-1:0] ptr_q, ptr_d;
   logic [IDXW-1:0] idx_q, idx_d;
   logic [N-1:0]    grant_q, grant_d;
   logic            valid_q, valid_d;
   logic            timeout_q, timeout_d;

   logic [IDXW-1:0] rot_amt;
   logic [2*N-1:0]  req_dbl;
   logic [N-1:0]    req_rot;
   logic [IDXW-1:0] pick_idx;
   logic            pick_valid;
   logic [IDXW-1:0] win_idx;

   // Rotate so that ptr lands on the top bit in round-robin mode, then map
   // the encoder result back to the true requester index
   always_comb begin
      rot_amt = rr_mode ? (IDXW'(N - 1) - ptr_q) : '0;
      req_dbl = {req, req} << rot_amt;
      req_rot = req_dbl[2*N-1:N];
      win_idx = pick_idx - rot_amt;
   end

   prio_pick #(
      .N    (N),
      .IDXW (IDXW)
   ) u_pick (
      .req_i   (req_rot),
      .idx_o   (pick_idx),
      .valid_o (pick_valid)
   );

   // Next-state and next-output logic; timeout is a single-cycle pulse
   always_comb begin
      state_d   = state_q;
      hold_d    = hold_q;
      ptr_d     = ptr_q;
      idx_d     = idx_q;
      grant_d   = grant_q;
      valid_d   = valid_q;
      timeout_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (pick_valid) begin
               state_d = ST_GRANT;
               idx_d   = win_idx;
               grant_d = N'(1) << win_idx;
               valid_d = 1'b1;
               hold_d  = '0;
               ptr_d   = win_idx - IDXW'(1);
            end
         end
         ST_GRANT: begin
            if (!req[idx_q] || (hold_q == HW'(MAX_HOLD - 1))) begin
               state_d   = ST_GAP;
               idx_d     = '0;
               grant_d   = '0;
               valid_d   = 1'b0;
               hold_d    = '0;
               // Only a forced release (owner still requesting) is a timeout
               timeout_d = req[idx_q];
            end else begin
               hold_d = hold_q + HW'(1);
            end
         end
         ST_GAP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            idx_d   = '0;
            grant_d = '0;
            valid_d = 1'b0;
            hold_d  = '0;
         end
      endcase
   end

   // State, counter, pointer and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         hold_q    <= '0;
         ptr_q     <= IDXW'(N - 1);
         idx_q     <= '0;
         grant_q   <= '0;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         hold_q    <= hold_d;
         ptr_q     <= ptr_d;
         idx_q     <= idx_d;
         grant_q   <= grant_d;
         valid_q   <= valid_d;
         timeout_q <= timeout_d;
      end
   end

   assign grant       = grant_q;
   assign grant_idx   = idx_q;
   assign grant_valid = valid_q;
   assign timeout     = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_prio_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : tb_prio_arbiter
// Brief   : Directed self-checking bench for prio_arbiter.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module tb_prio_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] req;
   logic       rr_mode;
   logic [7:0] grant;
   logic [2:0] grant_idx;
   logic       grant_valid;
   logic       timeout;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   prio_arbiter #(
      .N        (8),
      .IDXW     (3),
      .MAX_HOLD (16)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .rr_mode     (rr_mode),
      .grant       (grant),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid),
      .timeout     (timeout)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic v, input logic [2:0] idx,
                          input logic [7:0] g, input logic to);
      chk({tag, ".valid"},   32'(grant_valid), 32'(v));
      chk({tag, ".idx"},     32'(grant_idx),   32'(idx));
      chk({tag, ".grant"},   32'(grant),       32'(g));
      chk({tag, ".timeout"}, 32'(timeout),     32'(to));
   endtask

   initial begin
      logic       hold_ok;
      int         n;
      int         cnt;
      logic [2:0] k;

      // Reset state
      rst = 1'b1; req = 8'h00; rr_mode = 1'b0;
      repeat (2) @(negedge clk);
      chk_all("reset", 1'b0, 3'd0, 8'h00, 1'b0);

      // First grant, then asynchronous reset in the middle of it
      rst = 1'b0; req = 8'h04;
      @(negedge clk);
      chk_all("first_grant", 1'b1, 3'd2, 8'h04, 1'b0);
      @(negedge clk);
      #2 rst = 1'b1; req = 8'h00;
      #1 chk_all("async_rst", 1'b0, 3'd0, 8'h00, 1'b0);
      @(negedge clk);
      rst = 1'b0; req = 8'h04;
      @(negedge clk);
      chk_all("post_rst", 1'b1, 3'd2, 8'h04, 1'b0);
      req = 8'h00;
      @(negedge clk);
      chk_all("drop_gap", 1'b0, 3'd0, 8'h00, 1'b0);
      @(negedge clk);

      // Fixed priority: 7 wins, then 5 after gap + idle decision
      req = 8'hA1;
      @(negedge clk);
      chk_all("fixed7", 1'b1, 3'd7, 8'h80, 1'b0);
      req = 8'h21;
      @(negedge clk);
      chk_all("fixed_gap", 1'b0, 3'd0, 8'h00, 1'b0);
      @(negedge clk);
      chk_all("fixed_idle", 1'b0, 3'd0, 8'h00, 1'b0);
      @(negedge clk);
      chk_all("fixed5", 1'b1, 3'd5, 8'h20, 1'b0);
      req = 8'h00;
      repeat (2) @(negedge clk);

      // No preemption by a higher requester
      req = 8'h04;
      @(negedge clk);
      chk_all("np_own2", 1'b1, 3'd2, 8'h04, 1'b0);
      req = 8'h84;
      repeat (3) @(negedge clk);
      chk_all("np_hold2", 1'b1, 3'd2, 8'h04, 1'b0);
      req = 8'h80;
      @(negedge clk);
      chk_all("np_gap", 1'b0, 3'd0, 8'h00, 1'b0);
      @(negedge clk);
      @(negedge clk);
      chk_all("np_own7", 1'b1, 3'd7, 8'h80, 1'b0);
      req = 8'h00;
      repeat (2) @(negedge clk);

      // Timeout boundary: 16 valid cycles, pulse, then 3 wins again
      req = 8'h08;
      @(negedge clk);
      chk_all("to_start", 1'b1, 3'd3, 8'h08, 1'b0);
      hold_ok = 1'b1;
      repeat (15) begin
         @(negedge clk);
         if (!(grant_valid && grant_idx == 3'd3 && !timeout)) hold_ok = 1'b0;
      end
      chk("to_hold16", 32'(hold_ok), 32'd1);
      @(negedge clk);
      chk_all("to_pulse", 1'b0, 3'd0, 8'h00, 1'b1);
      @(negedge clk);
      chk_all("to_idle", 1'b0, 3'd0, 8'h00, 1'b0);
      @(negedge clk);
      chk_all("to_regrant", 1'b1, 3'd3, 8'h08, 1'b0);
      repeat (15) @(negedge clk);
      chk("to_cycle16", 32'(grant_valid), 32'd1);
      req = 8'h00;
      @(negedge clk);
      chk_all("to_drop16", 1'b0, 3'd0, 8'h00, 1'b0);
      @(negedge clk);

      // Mode switch during grant: fixed pick 5 (ptr->4), then RR picks 2
      rr_mode = 1'b0; req = 8'h24;
      @(negedge clk);
      chk_all("ms_fixed5", 1'b1, 3'd5, 8'h20, 1'b0);
      rr_mode = 1'b1;
      repeat (2) @(negedge clk);
      chk_all("ms_hold5", 1'b1, 3'd5, 8'h20, 1'b0);
      req = 8'hA4;
      @(negedge clk);
      chk_all("ms_ignore", 1'b1, 3'd5, 8'h20, 1'b0);
      req = 8'h84;
      @(negedge clk);
      chk_all("ms_gap", 1'b0, 3'd0, 8'h00, 1'b0);
      @(negedge clk);
      @(negedge clk);
      chk_all("ms_rr2", 1'b1, 3'd2, 8'h04, 1'b0);
      req = 8'h00;
      repeat (2) @(negedge clk);

      // Round-robin rotation with all requesting, every ownership times out
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; rr_mode = 1'b1; req = 8'hFF;
      for (int i = 0; i < 9; i++) begin
         k = (i == 8) ? 3'd7 : 3'(7 - i);
         n = 0;
         while (!grant_valid && n < 5) begin
            @(negedge clk);
            n++;
         end
         chk($sformatf("rr%0d.idx", i),   32'(grant_idx), 32'(k));
         chk($sformatf("rr%0d.grant", i), 32'(grant),     32'(8'd1 << k));
         cnt = 0;
         while (grant_valid && cnt < 40) begin
            cnt++;
            @(negedge clk);
         end
         chk($sformatf("rr%0d.len", i),     32'(cnt),     32'd16);
         chk($sformatf("rr%0d.timeout", i), 32'(timeout), 32'd1);
      end
      req = 8'h00;
      repeat (3) @(negedge clk);
      chk_all("final_idle", 1'b0, 3'd0, 8'h00, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
